seven_segment_scan_driver: RTL and testbench
============================================

Name: seven_segment_scan_driver

Overview:
- Parametrised multiplexed driver for an N-digit common-anode 7-segment display; successor to the single-digit hex decoder.
- Adds time-multiplexed digit scanning, per-digit enables, leading-zero blanking, PWM brightness, inter-digit ghost guard and frame-coherent data capture.
- Sits between top-level display data and the board pins (CA..CG, DP, AN).

Parameters:
- NUM_DIGITS, 4, number of digits scanned (1..8).
- REFRESH_DIV, 100000, clocks per digit slot; must be > GUARD_CYCLES.
- GUARD_CYCLES, 2, clocks at the start of each slot with all anodes off.
- BRIGHT_W, 4, width of the brightness input and of the PWM counter.

Ports:
- clk, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- data, input, 4*NUM_DIGITS, hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is the rightmost.
- dp_in, input, NUM_DIGITS, decimal point per digit; 1 = lit.
- digit_en, input, NUM_DIGITS, per-digit enable; 0 forces the digit dark.
- blank_lz, input, 1, enables leading-zero blanking.
- brightness, input, BRIGHT_W, PWM duty; 0 = off, all-ones = 100%.
- CA..CG, output, 1 each, segments; active-low.
- DP, output, 1, decimal point; active-low.
- AN, output, NUM_DIGITS, digit anodes; active-low.

Behaviour:
- Reset (async, reset_n=0): AN all 1; CA..CG and DP = 1; idx=0; slot_cnt=0; pwm_cnt=0; shadow data/dp = 0; load_pending=1.
- slot_cnt counts 0..REFRESH_DIV-1 and wraps. tick = (slot_cnt==REFRESH_DIV-1).
- On tick, idx advances to idx+1, wrapping from NUM_DIGITS-1 to 0.
- pwm_cnt is a free-running BRIGHT_W-bit counter that increments every clock.
- Shadow capture:
  - shadow_data/shadow_dp load from data/dp_in when load_pending=1, or on a tick with idx==NUM_DIGITS-1 (frame wrap).
  - load_pending clears after the first load.
  - Input changes mid-frame are never displayed until the next frame.
- Leading-zero blanking (blank_lz=1):
  - Digit i (i>=1) is blanked if its shadow nibble is 0, its shadow dp is 0, and every digit above it is also blanked.
  - Digit 0 is never blanked.
- The current digit is lit when all of the following hold:
  - digit_en[idx]=1;
  - the digit is not blanked;
  - slot_cnt >= GUARD_CYCLES;
  - brightness is all-ones, or pwm_cnt < brightness.
- Outputs are registered; they reflect the state (idx, slot_cnt, pwm_cnt, shadow) of the previous clock, i.e. 1-cycle latency.
- When lit:
  - AN = all 1 except AN[idx]=0;
  - CA..CG = inverted decode of the shadow nibble;
  - DP = ~shadow_dp[idx].
- When not lit: AN all 1; CA..CG and DP = 1.
- Decode (ABCDEFG, 1 = on):
  - 0 → 1111110, 1 → 0110000, 2 → 1101101, 3 → 1111001;
  - 4 → 0110011, 5 → 1011011, 6 → 1011111, 7 → 1110000;
  - 8 → 1111111, 9 → 1111011, A → 1110111, b → 0011111;
  - C → 1001110, d → 0111101, E → 1001111, F → 1000111.
- At most one AN bit is low in any cycle.
- Reset asserted mid-slot: outputs go dark immediately, without waiting for clk. After release, scanning restarts at idx 0 and the shadow loads on the first clock.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=8, GUARD_CYCLES=2, BRIGHT_W=2):
- Reset: drop reset_n mid-slot with AN=1011 → AN=1111 and CA..CG, DP = 1 within the same cycle. Release → first lit AN=1110 at slot_cnt 2 (output seen on the following clock).
- Scan order: data=16'h1234, dp_in=0, digit_en=1111, brightness=3, blank_lz=0.
  - AN cycles 1110 → 1101 → 1011 → 0111, each low for 6 of every 8 clocks, with all anodes high for the 2 guard clocks.
  - Digit 0 segments CA..CG = 1001100 ('4').
- Leading-zero blanking, blank_lz=1:
  - data=16'h0070 → AN[3] and AN[2] never low; digits show '7' and '0'.
  - data=16'h0000 → only AN[0] ever goes low, showing '0'.
  - data=16'h0005, dp_in=0100 → digit 2 shows '0' with DP=0; digits 2, 1 and 0 are lit; digit 3 stays dark.
- Brightness:
  - brightness=1 → anode low only when pwm_cnt==0 outside the guard window.
  - brightness=0 → AN stays 1111 forever.
  - brightness=3 → anode low on every non-guard clock.
- Frame coherence: change data from 16'h1111 to 16'h2222 while idx=1 → digits 1..3 still show '1' for the rest of the frame; '2' appears from the next idx=0 slot.
- Enables: digit_en=1010 → AN[0] and AN[2] never low; AN[1] and AN[3] scan normally.

Source files
------------

// File: rtl/seven_segment_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment scan driver.
// Scans one digit per slot. Each slot opens with a dark guard window.
// Brightness is set by PWM. Leading zeros can be blanked.
// Display data is captured once per frame so a frame never mixes old and new values.
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int GUARD_CYCLES = 2,
  parameter int BRIGHT_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*NUM_DIGITS-1:0] data,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  input  logic [BRIGHT_W-1:0]     brightness,
  output logic                    CA,
  output logic                    CB,
  output logic                    CC,
  output logic                    CD,
  output logic                    CE,
  output logic                    CF,
  output logic                    CG,
  output logic                    DP,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  // Hex nibble to segment pattern, ABCDEFG order, 1 = segment on.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_decode = 7'b1111110;
      4'h1:    hex_decode = 7'b0110000;
      4'h2:    hex_decode = 7'b1101101;
      4'h3:    hex_decode = 7'b1111001;
      4'h4:    hex_decode = 7'b0110011;
      4'h5:    hex_decode = 7'b1011011;
      4'h6:    hex_decode = 7'b1011111;
      4'h7:    hex_decode = 7'b1110000;
      4'h8:    hex_decode = 7'b1111111;
      4'h9:    hex_decode = 7'b1111011;
      4'hA:    hex_decode = 7'b1110111;
      4'hB:    hex_decode = 7'b0011111;
      4'hC:    hex_decode = 7'b1001110;
      4'hD:    hex_decode = 7'b0111101;
      4'hE:    hex_decode = 7'b1001111;
      4'hF:    hex_decode = 7'b1000111;
      default: hex_decode = 7'b0000000;
    endcase
  endfunction

  logic [SLOT_W-1:0]       r_slot_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [BRIGHT_W-1:0]     r_pwm_cnt;
  logic [4*NUM_DIGITS-1:0] r_shadow_data;
  logic [NUM_DIGITS-1:0]   r_shadow_dp;
  logic                    r_load_pending;
  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_seg_n;
  logic                    r_dp_n;

  logic                    w_tick;
  logic                    w_frame_wrap;
  logic [NUM_DIGITS-1:0]   w_blank;
  logic                    w_chain;
  logic [3:0]              w_cur_nib;
  logic                    w_cur_dp;
  logic                    w_bright_ok;
  logic                    w_lit;
  logic [NUM_DIGITS-1:0]   w_an_next;

  assign w_tick       = (r_slot_cnt == SLOT_LAST);
  assign w_frame_wrap = w_tick && (r_idx == IDX_LAST);

  // Slot timer, digit index and free-running PWM counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_slot_cnt <= '0;
      r_idx      <= '0;
      r_pwm_cnt  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + BRIGHT_W'(1);
      if (w_tick) begin
        r_slot_cnt <= '0;
        if (r_idx == IDX_LAST) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + IDX_W'(1);
        end
      end else begin
        r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
      end
    end
  end

  // Frame-coherent capture of display data: once after reset, then at every frame wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow_data  <= '0;
      r_shadow_dp    <= '0;
      r_load_pending <= 1'b1;
    end else if (r_load_pending || w_frame_wrap) begin
      r_shadow_data  <= data;
      r_shadow_dp    <= dp_in;
      r_load_pending <= 1'b0;
    end else begin
      r_load_pending <= 1'b0;
    end
  end

  // Leading-zero blanking: walk down from the top digit while digits stay zero with no DP.
  always_comb begin
    w_blank = '0;
    w_chain = blank_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      w_chain    = w_chain && (r_shadow_data[4*i +: 4] == 4'h0) && !r_shadow_dp[i];
      w_blank[i] = w_chain;
    end
  end

  // Decide whether the current digit is lit, and build the next anode pattern.
  always_comb begin
    w_cur_nib   = r_shadow_data[{r_idx, 2'b00} +: 4];
    w_cur_dp    = r_shadow_dp[r_idx];
    w_bright_ok = (brightness == '1) || (r_pwm_cnt < brightness);
    w_lit       = digit_en[r_idx] && !w_blank[r_idx] &&
                  (r_slot_cnt >= GUARD_END) && w_bright_ok;
    w_an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_an_next[i] = !(w_lit && (r_idx == IDX_W'(i)));
    end
  end

  // Registered pin drivers. Reset darkens the display immediately, without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_an    <= '1;
      r_seg_n <= 7'b1111111;
      r_dp_n  <= 1'b1;
    end else begin
      r_an <= w_an_next;
      if (w_lit) begin
        r_seg_n <= ~hex_decode(w_cur_nib);
        r_dp_n  <= ~w_cur_dp;
      end else begin
        r_seg_n <= 7'b1111111;
        r_dp_n  <= 1'b1;
      end
    end
  end

  assign AN = r_an;
  assign CA = r_seg_n[6];
  assign CB = r_seg_n[5];
  assign CC = r_seg_n[4];
  assign CD = r_seg_n[3];
  assign CE = r_seg_n[2];
  assign CF = r_seg_n[1];
  assign CG = r_seg_n[0];
  assign DP = r_dp_n;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Bench for seven_segment_scan_driver, built with 4 digits, 8-clock slots,
// a 2-clock guard and 2-bit brightness.
// Expected pins are computed from the elapsed clock count since reset release
// and from a shadow copy of the data captured at each frame boundary.
module tb_seven_segment_scan_driver;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [15:0]   data;
  logic [3:0]    dp_in;
  logic [3:0]    digit_en;
  logic          blank_lz;
  logic [BW-1:0] brightness;
  logic          CA, CB, CC, CD, CE, CF, CG, DP;
  logic [3:0]    AN;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int         k;
  logic [15:0] m_data;
  logic [3:0]  m_dp;
  logic [3:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_dp;
  logic [6:0]  SEG_ON [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                               7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  seven_segment_scan_driver #(
    .NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BRIGHT_W(BW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .dp_in(dp_in),
    .digit_en(digit_en), .blank_lz(blank_lz), .brightness(brightness),
    .CA(CA), .CB(CB), .CC(CC), .CD(CD), .CE(CE), .CF(CF), .CG(CG),
    .DP(DP), .AN(AN)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  function automatic logic [6:0] segs();
    return {CA, CB, CC, CD, CE, CF, CG};
  endfunction

  // A digit is blanked when it and every digit above it is zero with no DP.
  function automatic logic blanked(input int i);
    if (!blank_lz || i == 0) return 1'b0;
    for (int j = i; j < ND; j++) begin
      if (m_data[4*j +: 4] != 4'h0 || m_dp[j]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s k=%0d observed=%b expected=%b", tag, k, obs, expv);
    end
  endtask

  // One clock: predict the pins from pre-edge state, clock, then compare.
  task automatic cycle();
    int   slot, idx, pwm;
    logic lit, load;
    logic [15:0] ld_data;
    logic [3:0]  ld_dp;
    slot = k % RD;
    idx  = (k / RD) % ND;
    pwm  = k % (1 << BW);
    lit  = digit_en[idx] && !blanked(idx) && (slot >= GC) &&
           (brightness == 2'd3 || pwm < int'(brightness));
    exp_an  = 4'b1111;
    exp_seg = 7'b1111111;
    exp_dp  = 1'b1;
    if (lit) begin
      exp_an[idx] = 1'b0;
      exp_seg     = ~SEG_ON[m_data[4*idx +: 4]];
      exp_dp      = ~m_dp[idx];
    end
    load    = (k == 0) || (k % (RD*ND) == RD*ND - 1);
    ld_data = data;
    ld_dp   = dp_in;
    @(posedge clk);
    #1;
    if (load) begin
      m_data = ld_data;
      m_dp   = ld_dp;
    end
    k++;
    check("an",  {4'h0, AN},     {4'h0, exp_an});
    check("seg", {1'b0, segs()}, {1'b0, exp_seg});
    check("dp",  {7'h0, DP},     {7'h0, exp_dp});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic model_reset();
    k      = 0;
    m_data = 16'h0000;
    m_dp   = 4'h0;
  endtask

  initial begin
    int   n;
    logic hit;
    reset_n = 1'b1; data = 16'h1234; dp_in = 4'h0; digit_en = 4'hF;
    blank_lz = 1'b0; brightness = 2'd3;
    model_reset();
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_an",  {4'h0, AN},     8'h0F);
    check("rst_seg", {1'b0, segs()}, 8'h7F);
    check("rst_dp",  {7'h0, DP},     8'h01);

    // Scan order with 1234; first lit anode is digit 0 after the third clock.
    reset_n = 1'b1;
    run(3);
    check("first_lit", {4'h0, AN}, 8'h0E);
    check("digit0_4",  {1'b0, segs()}, {1'b0, 7'b1001100});
    run(77);

    // Mid-slot async reset while digit 2 is lit.
    hit = 1'b0;
    for (n = 0; n < 64 && !hit; n++) begin
      cycle();
      hit = (exp_an == 4'b1011);
    end
    check("wait_an1011", {7'h0, hit}, 8'h01);
    #2 reset_n = 1'b0;
    #1;
    check("async_an",  {4'h0, AN},     8'h0F);
    check("async_seg", {1'b0, segs()}, 8'h7F);
    check("async_dp",  {7'h0, DP},     8'h01);
    @(posedge clk);
    #1;
    model_reset();
    reset_n = 1'b1;
    run(40);

    // Leading-zero blanking.
    blank_lz = 1'b1;
    data = 16'h0070; run(72);
    data = 16'h0000; run(72);
    data = 16'h0005; dp_in = 4'b0100; run(72);

    // Brightness.
    blank_lz = 1'b0; data = 16'h89AB; dp_in = 4'b1010;
    brightness = 2'd1; run(72);
    brightness = 2'd0; run(40);
    brightness = 2'd3; run(40);

    // Frame coherence: switch 1111 -> 2222 during the idx 1 slot.
    dp_in = 4'h0; data = 16'h1111; run(40);
    while ((k / RD) % ND != 1) cycle();
    data = 16'h2222;
    hit = 1'b0;
    for (n = 0; n < 64 && !hit; n++) begin
      cycle();
      hit = ((k / RD) % ND == 3) && (k % RD == 5);
    end
    check("coh_wait3", {7'h0, hit}, 8'h01);
    check("coh_old",   {1'b0, segs()}, {1'b0, 7'b1001111});
    hit = 1'b0;
    for (n = 0; n < 64 && !hit; n++) begin
      cycle();
      hit = ((k / RD) % ND == 0) && (k % RD == 5);
    end
    check("coh_wait0", {7'h0, hit}, 8'h01);
    check("coh_new",   {1'b0, segs()}, {1'b0, 7'b0010010});

    // Per-digit enables.
    digit_en = 4'b1010; data = 16'h5A3C; run(72);

    // Randomised inputs, changed at random cycles.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        data       = 16'($urandom);
        dp_in      = 4'($urandom);
        digit_en   = 4'($urandom);
        blank_lz   = 1'($urandom);
        brightness = 2'($urandom);
        if ($urandom_range(0, 2) == 0) data[15:8] = 8'h00;
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
